// File: rtl/mem_access_ctrl.sv
// Load/store unit between the execute stage and a fixed-latency data memory.
// Handles alignment/range checks, lane extraction and read-modify-write for SH/SB.
module mem_access_ctrl #(
  parameter int RD_LAT    = 2,
  parameter int MEM_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [2:0]  OP_LW  = 3'd0;
  localparam logic [2:0]  OP_LH  = 3'd1;
  localparam logic [2:0]  OP_LHU = 3'd2;
  localparam logic [2:0]  OP_LB  = 3'd3;
  localparam logic [2:0]  OP_LBU = 3'd4;
  localparam logic [2:0]  OP_SW  = 3'd5;
  localparam logic [2:0]  OP_SH  = 3'd6;
  localparam logic [1:0]  LAST_RD = 2'(RD_LAT - 1);
  localparam logic [29:0] DEPTH   = 30'(MEM_DEPTH);

  state_t      state;
  logic [1:0]  cnt;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [1:0]  acc_err;

  function automatic logic [1:0] access_err(input logic [2:0] op, input logic [31:0] addr);
    logic mis;
    mis = ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00) ||
          ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]);
    if (mis) return 2'b01;
    if (addr[31:2] >= DEPTH) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'h0000, h};
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'h000000, b};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lane,
                                              input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (op == OP_SH) begin
      if (lane[1]) r[31:16] = wd;
      else         r[15:0]  = wd;
    end else begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end
    return r;
  endfunction

  assign acc_err   = access_err(req_op, req_addr);
  assign req_ready = rst && (state == IDLE);
  assign busy      = (state != IDLE);

  // Request latch: only lane and low store bits are needed after acceptance
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      op_q    <= req_op;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      resp_err   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (acc_err != 2'b00) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= acc_err;
            end else if (req_op == OP_SW) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= {2'b00, req_addr[31:2]};
              mem_wdata <= req_wdata;
            end else begin
              state    <= READ;
              mem_re   <= 1'b1;
              mem_addr <= {2'b00, req_addr[31:2]};
              cnt      <= 2'd0;
            end
          end
        end
        READ: begin
          if (cnt == LAST_RD) begin
            mem_re <= 1'b0;
            // Sub-word stores reuse the fetched word for the merge
            if (op_q > OP_LBU) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= store_merge(op_q, lane_q, mem_rdata, wdata_q);
            end else begin
              state      <= RESP;
              mem_addr   <= 32'd0;
              resp_valid <= 1'b1;
              resp_data  <= load_extract(op_q, lane_q, mem_rdata);
            end
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_we     <= 1'b0;
          mem_addr   <= 32'd0;
          mem_wdata  <= 32'd0;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_data  <= 32'd0;
          resp_err   <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares them against a small memory model.
module tb_mem_access_ctrl;
  localparam int RD_LAT    = 2;
  localparam int MEM_DEPTH = 32;
  localparam int P         = 10;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4,
                         SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic        clk, rst, req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, busy;
  logic [31:0] resp_data;
  logic [1:0]  resp_err;

  mem_access_ctrl #(.RD_LAT(RD_LAT), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
    int          re;
    int          we;
    time         acc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory model: data only presented on the last cycle of a RD_LAT-long read burst
  logic [31:0] mem [MEM_DEPTH];
  int          re_run = 0;
  bit          mem_loaded = 1'b0;

  assign mem_rdata = (mem_re && re_run == RD_LAT - 1) ? mem[mem_addr[4:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= (i == 3) ? 32'h8081_F0F2 : 32'(i) * 32'h0101_0101;
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
    end
    re_run <= mem_re ? re_run + 1 : 0;
  end

  // Monitor
  initial begin
    int   re_cnt;
    int   we_cnt;
    int   lat;
    exp_t e;
    wr_t  w;
    re_cnt = 0;
    we_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        re_cnt = 0;
        we_cnt = 0;
      end else begin
        chk("re_we_overlap", {31'd0, mem_re & mem_we}, 32'd0);
        if (!resp_valid) chk("resp_data_quiet", resp_data, 32'd0);
        if (!busy) begin
          chk("idle_ctrl", {29'd0, mem_re, mem_we, resp_valid}, 32'd0);
          chk("idle_mem_addr", mem_addr, 32'd0);
          chk("idle_mem_wdata", mem_wdata, 32'd0);
        end
        if (mem_re) re_cnt++;
        if (mem_we) begin
          we_cnt++;
          if (wr_q.size() == 0) begin
            chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
          end else begin
            w = wr_q.pop_front();
            chk("write_addr", mem_addr, w.addr);
            chk("write_data", mem_wdata, w.wdata);
          end
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", resp_data, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            // resp seen here is sampled by a consumer at the next rising edge
            lat = int'(($time - e.acc + P/2) / P);
            chk("resp_data", resp_data, e.data);
            chk("resp_err", {30'd0, resp_err}, {30'd0, e.err});
            chk("resp_latency", lat, e.lat);
            chk("mem_re_cycles", re_cnt, e.re);
            chk("mem_we_cycles", we_cnt, e.we);
            chk("resp_busy", {31'd0, busy}, 32'd1);
          end
          re_cnt = 0;
          we_cnt = 0;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] edata, input logic [1:0] eerr, input int lat,
                       input int ere, input int ewe, input logic [31:0] waddr,
                       input logic [31:0] wwdata, input bit push);
    int   n;
    exp_t e;
    wr_t  w;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk);
    if (push) begin
      e.data = edata; e.err = eerr; e.lat = lat; e.re = ere; e.we = ewe; e.acc = $time;
      exp_q.push_back(e);
      if (ewe != 0) begin
        w.addr = waddr; w.wdata = wwdata;
        wr_q.push_back(w);
      end
    end
    // Valid stays high with scrambled fields: the busy block must ignore them
    #1;
    req_op    = ~op;
    req_addr  = ~addr;
    req_wdata = ~wd;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pending_resp", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, req_ready, busy, mem_re, mem_we, resp_valid}, 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_after_reset", {30'd0, req_ready, busy}, 32'd2);

    issue(LB,  32'h0D, 32'h0,         32'hFFFF_FFF0, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(LHU, 32'h0E, 32'h0,         32'h0000_8081, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(LH,  32'h0E, 32'h0,         32'hFFFF_8081, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(LW,  32'h0C, 32'h0,         32'h8081_F0F2, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(LBU, 32'h0D, 32'h0,         32'h0000_00F0, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(SB,  32'h0D, 32'h0000_00AA, 32'h0,         2'b00, 4, 2, 1, 32'd3, 32'h8081_AAF2, 1);
    issue(LW,  32'h0C, 32'h0,         32'h8081_AAF2, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(SH,  32'h0E, 32'h1234_5678, 32'h0,         2'b00, 4, 2, 1, 32'd3, 32'h5678_AAF2, 1);
    issue(LW,  32'h06, 32'h0,         32'h0,         2'b01, 1, 0, 0, 0, 0, 1);
    issue(SW,  32'h80, 32'h1,         32'h0,         2'b10, 1, 0, 0, 0, 0, 1);
    issue(LH,  32'h81, 32'h0,         32'h0,         2'b01, 1, 0, 0, 0, 0, 1);
    issue(LW,  32'h7C, 32'h0,         32'h1F1F_1F1F, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(LB,  32'h7F, 32'h0,         32'h0000_001F, 2'b00, 3, 2, 0, 0, 0, 1);
    issue(SW,  32'h10, 32'hCAFE_BABE, 32'h0,         2'b00, 2, 0, 1, 32'd4, 32'hCAFE_BABE, 1);
    issue(LW,  32'h10, 32'h0,         32'hCAFE_BABE, 2'b00, 3, 2, 0, 0, 0, 1);
    idle_bus();
    drain();

    // Abort an SH during its second read cycle
    issue(SH, 32'h0C, 32'h0000_BEEF, 32'h0, 2'b00, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, req_ready, busy, mem_re, mem_we, resp_valid}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1'b1;
    issue(LW, 32'h0C, 32'h0, 32'h5678_AAF2, 2'b00, 3, 2, 0, 0, 0, 1);
    idle_bus();
    drain();
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter RD_LAT, default 2, data-memory read latency in cycles; legal range 1..4.
REQ-002 Parameter MEM_DEPTH, default 32, number of 32-bit words in the attached data memory.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  execute stage presents a memory request.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-008 req_addr  input  32  byte address from ALU.
REQ-009 req_wdata  input  32  store data, right-aligned for SH/SB.
REQ-010 mem_re  output  1  data-memory read enable.
REQ-011 mem_we  output  1  data-memory write enable.
REQ-012 mem_addr  output  32  word address, equal to latched req_addr[31:2].
REQ-013 mem_wdata  output  32  full word to write.
REQ-014 mem_rdata  input  32  data-memory read word.
REQ-015 resp_valid  output  1  one-cycle completion pulse.
REQ-016 resp_data  output  32  load result; 0 for stores, errors, and whenever resp_valid=0.
REQ-017 resp_err  output  2  00 ok, 01 misaligned, 10 out of range.
REQ-018 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-019 FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-020 Accept on rising edge with req_valid=1 and req_ready=1; latch op, addr, wdata; later input changes are ignored.
REQ-021 Check at acceptance: misaligned if LW/SW with addr[1:0]!=0 or LH/LHU/SH with addr[0]!=0; out of range if addr[31:2]>=MEM_DEPTH; misaligned has priority.
REQ-022 Erroring request: IDLE->RESP with no mem_re/mem_we, resp_err set, resp_data=0.
REQ-023 Loads and SH/SB: IDLE->READ; mem_re=1 for exactly RD_LAT consecutive cycles with mem_addr stable; mem_rdata sampled on the edge ending the last READ cycle.
REQ-024 Load exit READ->RESP; load latency from accept edge to resp_valid high = RD_LAT+1 cycles.
REQ-025 Load extraction little-endian: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes word.
REQ-026 SW: IDLE->WRITE; one cycle mem_we=1, mem_wdata=req_wdata; then RESP; latency 2 cycles.
REQ-027 SH/SB: read-modify-write; READ->WRITE; mem_wdata = sampled word with selected lane replaced by req_wdata[15:0] or [7:0]; latency RD_LAT+2 cycles.
REQ-028 RESP lasts exactly one cycle with resp_valid=1, then IDLE; next request accepted no earlier than the cycle after RESP.
REQ-029 mem_re and mem_we never high in the same cycle; in IDLE and RESP both 0, mem_addr=0, mem_wdata=0.
REQ-030 req_valid=1 while not ready is ignored; request must be held by upstream until accepted.

Reset
REQ-031 rst=0 forces asynchronously: state IDLE, counter 0, all outputs 0 except req_ready=1 once rst=1.
REQ-032 Reset mid-operation aborts the in-flight op; no mem_we, no resp_valid is produced for it.

Verification
REQ-033 Memory word 3 = 0x8081_F0F2; LB addr 0x0D -> resp_data 0xFFFF_FFF0, err 00, resp_valid 3 cycles after accept.
REQ-034 Same word; LHU addr 0x0E -> 0x0000_8081; LH addr 0x0E -> 0xFFFF_8081; LW addr 0x0C -> 0x8081_F0F2.
REQ-035 SB addr 0x0D, wdata 0x0000_00AA over word 0x8081_F0F2 -> one mem_we with mem_addr 3, mem_wdata 0x8081_AAF2, resp_valid 4 cycles after accept.
REQ-036 LW addr 0x06 -> resp_err 01, no mem_re; SW addr 0x80 (word 32) -> resp_err 10, no mem_we; resp_valid 1 cycle after accept.
REQ-037 SH accepted, rst=0 during second READ cycle -> outputs 0 immediately, no mem_we, no resp_valid; first request after release completes normally.
REQ-038 Back-to-back SW then LW, req_valid held high -> second accepted the cycle after first RESP; mem_re/mem_we never overlap.
